weight_load_ctrl: RTL and testbench
===================================

Name: weight_load_ctrl

Overview:
Upstream sequencer for the per-column weight shifter registers of the systolic array. On start it reads one weight tile of ARRAYHEIGHT rows from the weight buffer, one row vector of ARRAYWIDTH weights per read. It pushes each row into all column shifters in parallel with the load strobe. It then drains the shifters into the array with the output strobe, pausing whenever the array is not ready.

Parameters:
DATASIZE, 16, bit width of one weight.
ARRAYHEIGHT, 4, rows per tile; equals the shifter depth.
ARRAYWIDTH, 4, columns; one shifter per column.
ADDRW, 8, weight buffer address width.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  reset; asynchronous, active-low.
start  in  1  one-cycle request to load a tile; ignored while busy=1.
base_addr  in  ADDRW  buffer address of tile row 0; sampled with start.
array_ready  in  1  array can accept a weight row this cycle.
mem_rd_en  out  1  buffer read strobe.
mem_addr  out  ADDRW  buffer read address.
mem_rdata  in  ARRAYWIDTH*DATASIZE  row vector; valid the cycle after mem_rd_en; column c at bits [c*DATASIZE +: DATASIZE].
sh_load_en  out  1  load strobe to all column shifters.
sh_data  out  ARRAYWIDTH*DATASIZE  per-column shifter input; same column packing as mem_rdata.
sh_out_en  out  1  output/shift strobe to all column shifters.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse after the last drain.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs and counters are 0: mem_rd_en, mem_addr, sh_load_en, sh_data, sh_out_en, busy, done. Reset mid-operation abandons the tile with no further strobes. Shifter contents are not this block's concern.
- States:
  - IDLE: start=1 captures base_addr, sets busy, and moves to READ.
  - READ: exactly ARRAYHEIGHT consecutive cycles with mem_rd_en=1. Read k (k=0..H-1) uses mem_addr = base+(H-1-k) mod 2^ADDRW. Rows are read in reverse so that row 0 is loaded last and drains first, because the shifter is last-in first-out. The state then moves to LOADTAIL.
  - Load pipeline: rd_valid is mem_rd_en delayed by one cycle. On rd_valid, mem_rdata is registered into sh_data and sh_load_en=1 on the next cycle. Each sh_load_en is therefore 2 cycles after its mem_rd_en, giving exactly H consecutive load pulses.
  - LOADTAIL: waits until the last sh_load_en has been issued, then moves to DRAIN.
  - DRAIN: sh_out_en = array_ready, combinational and gated by state. A drain counter increments on each cycle with sh_out_en=1. After H strobes the state moves to FIN. While array_ready=0, sh_out_en=0 and the count holds; the stall may be indefinite.
  - FIN: done=1 and busy=0 for one cycle, then IDLE. A start in the FIN cycle is ignored.
- sh_out_en and sh_load_en are never high in the same cycle. sh_data holds its last value when sh_load_en=0.
- Timing with no stalls, cycle 0 = edge that samples start: mem_rd_en cycles 1..H, sh_load_en 3..H+2, sh_out_en H+3..2H+2, done 2H+3. For H=4: rd 1-4, load 3-6, drain 7-10, done 11.
- The address adder is ADDRW bits wide and wraps silently.

Test Plan:
- Reset then idle, H=W=4: outputs all 0; rst pulsed low between edges clears outputs immediately.
- start with base=0x10, buffer row r = {4{r+1}}, array_ready=1: mem_addr sequence 0x13,0x12,0x11,0x10 on cycles 1-4; sh_data 4,3,2,1 (per column) on cycles 3-6; sh_out_en cycles 7-10; done on cycle 11 only; busy cycles 1-10.
- Same as previous, array_ready=0 on cycles 7-9 and 12: sh_out_en on 10,11,13,14 only; done on cycle 15.
- base=0xFE: mem_addr sequence 0x01,0x00,0xFF,0xFE (wrap).
- start pulsed during READ and again in the FIN cycle: both ignored; exactly one tile transfer; no second read burst.
- rst low at cycle 5 of a transfer: all outputs 0 at once; after rst releases, no strobes until a new start; the new start runs the full nominal sequence.

Source files
------------

// File: rtl/weight_load_ctrl.sv
// Weight tile loader: reads H buffer rows in reverse, pushes them into the
// per-column LIFO shifters, then drains them into the array under array_ready.
module weight_load_ctrl #(
    parameter int unsigned DATASIZE    = 16,
    parameter int unsigned ARRAYHEIGHT = 4,
    parameter int unsigned ARRAYWIDTH  = 4,
    parameter int unsigned ADDRW       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDRW-1:0]               base_addr,
    input  logic                           array_ready,
    output logic                           mem_rd_en,
    output logic [ADDRW-1:0]               mem_addr,
    input  logic [ARRAYWIDTH*DATASIZE-1:0] mem_rdata,
    output logic                           sh_load_en,
    output logic [ARRAYWIDTH*DATASIZE-1:0] sh_data,
    output logic                           sh_out_en,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned ROWW = ARRAYWIDTH * DATASIZE;
    localparam int unsigned CNTW = $clog2(ARRAYHEIGHT + 1);
    localparam logic [CNTW-1:0]  H_CNT   = CNTW'(ARRAYHEIGHT);
    localparam logic [ADDRW-1:0] ROW_TOP = ADDRW'(ARRAYHEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOADTAIL,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [ADDRW-1:0] r_base;
    logic [CNTW-1:0]  r_rcnt;
    logic [CNTW-1:0]  r_dcnt;
    logic             r_mem_rd_en;
    logic [ADDRW-1:0] r_mem_addr;
    logic             r_rd_valid;
    logic             r_sh_load_en;
    logic [ROWW-1:0]  r_sh_data;
    logic             r_busy;
    logic             r_done;

    logic             w_out_en;
    logic             w_last_drain;

    assign w_out_en     = (r_state == S_DRAIN) && array_ready;
    assign w_last_drain = (r_dcnt == (H_CNT - CNTW'(1)));

    assign mem_rd_en  = r_mem_rd_en;
    assign mem_addr   = r_mem_addr;
    assign sh_load_en = r_sh_load_en;
    assign sh_data    = r_sh_data;
    assign sh_out_en  = w_out_en;
    assign busy       = r_busy;
    assign done       = r_done;

    // Load pipeline: read data lands one cycle after the strobe, is registered, then loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid   <= 1'b0;
            r_sh_load_en <= 1'b0;
            r_sh_data    <= '0;
        end else begin
            r_rd_valid   <= r_mem_rd_en;
            r_sh_load_en <= r_rd_valid;
            if (r_rd_valid) begin
                r_sh_data <= mem_rdata;
            end
        end
    end

    // Sequencer: rows are fetched top-down so row 0 enters the LIFO last and leaves first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_rcnt      <= '0;
            r_dcnt      <= '0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_base      <= base_addr;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= base_addr + ROW_TOP;
                        r_rcnt      <= CNTW'(1);
                        r_dcnt      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_rcnt == H_CNT) begin
                        r_mem_rd_en <= 1'b0;
                        r_state     <= S_LOADTAIL;
                    end else begin
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_base + ROW_TOP - ADDRW'(r_rcnt);
                        r_rcnt      <= r_rcnt + CNTW'(1);
                    end
                end
                S_LOADTAIL: begin
                    // Final load pulse is the one with nothing left in flight behind it.
                    if (r_sh_load_en && !r_rd_valid) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_out_en) begin
                        r_dcnt <= r_dcnt + CNTW'(1);
                        if (w_last_drain) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: per-cycle traces compared against a timeline model
// built from the tile timing rules and a buffer model.
module tb_weight_load_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned H  = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned RW = W * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          array_ready = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [RW-1:0] mem_rdata = '0;
    logic          sh_load_en;
    logic [RW-1:0] sh_data;
    logic          sh_out_en;
    logic          busy;
    logic          done;

    weight_load_ctrl #(
        .DATASIZE(DW), .ARRAYHEIGHT(H), .ARRAYWIDTH(W), .ADDRW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .array_ready(array_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .sh_load_en(sh_load_en), .sh_data(sh_data),
        .sh_out_en(sh_out_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Weight buffer: one-cycle read latency.
    logic [RW-1:0] mem [0:255];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int n_cmp;
    int n_fail;

    bit            g_ready [0:63];
    bit            g_start [0:63];
    logic [4:0]    act_strb [0:63];
    logic [4:0]    exp_strb [0:63];
    logic [AW-1:0] act_addr [0:63];
    logic [AW-1:0] exp_addr [0:63];
    logic [RW-1:0] act_data [0:63];
    logic [RW-1:0] exp_data [0:63];
    logic [RW-1:0] g_last_data;
    int            g_last;

    task automatic clear_stim();
        for (int c = 0; c < 64; c++) begin
            g_ready[c] = 1'b1;
            g_start[c] = 1'b0;
        end
        g_start[0] = 1'b1;
    endtask

    // Timeline model, cycle 0 = edge sampling start; strobe bits {rd, ld, oe, busy, done}.
    task automatic build_expected(input logic [AW-1:0] base);
        int cnt;
        logic [RW-1:0] cur;
        cnt = 0;
        cur = g_last_data;
        g_last = 0;
        for (int c = 0; c < 64; c++) begin
            exp_strb[c] = '0;
            exp_addr[c] = '0;
        end
        for (int k = 0; k < H; k++) begin
            exp_strb[k+1][4] = 1'b1;
            exp_addr[k+1]    = base + AW'(H - 1 - k);
            exp_strb[k+3][3] = 1'b1;
        end
        for (int c = H + 3; c < 64 && cnt < H; c++) begin
            if (g_ready[c]) begin
                exp_strb[c][2] = 1'b1;
                cnt++;
                g_last = c;
            end
        end
        for (int c = 1; c <= g_last; c++) exp_strb[c][1] = 1'b1;
        exp_strb[g_last+1][0] = 1'b1;
        for (int c = 0; c < 64; c++) begin
            if (exp_strb[c][3]) cur = mem[exp_addr[c-2]];
            exp_data[c] = cur;
        end
    endtask

    task automatic run_capture(input logic [AW-1:0] base, input int ncyc);
        @(negedge clk);
        start = g_start[0]; base_addr = base; array_ready = g_ready[0];
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = g_start[c]; base_addr = AW'($urandom); array_ready = g_ready[c];
            @(negedge clk);
            act_strb[c] = {mem_rd_en, sh_load_en, sh_out_en, busy, done};
            act_addr[c] = mem_addr;
            act_data[c] = sh_data;
        end
        @(posedge clk); #1;
        start = 1'b0; array_ready = 1'b1;
        g_last_data = exp_data[ncyc];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({mem_rd_en, sh_load_en, sh_out_en, busy, done} !== 5'b0) begin
            n_fail++; $display("FAIL reset strobes: got %b want 00000", {mem_rd_en, sh_load_en, sh_out_en, busy, done});
        end
        n_cmp++;
        if (mem_addr !== '0) begin n_fail++; $display("FAIL reset mem_addr: got %h want 00", mem_addr); end
        n_cmp++;
        if (sh_data !== '0) begin n_fail++; $display("FAIL reset sh_data: got %h want 0", sh_data); end
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_rd_en, sh_load_en, sh_out_en, busy, done} !== 5'b0) begin
                n_fail++; $display("FAIL idle strobes %0d: got %b want 00000", c, {mem_rd_en, sh_load_en, sh_out_en, busy, done});
            end
        end
        g_last_data = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int ncyc;
        clear_stim();
        for (int r = 0; r < H; r++) mem[8'h10 + r] = {4{16'(r + 1)}};
        build_expected(8'h10);
        ncyc = g_last + 3;
        run_capture(8'h10, ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            n_cmp++;
            if (act_strb[c] !== exp_strb[c]) begin n_fail++; $display("FAIL nominal strobes c%0d: got rd,ld,oe,busy,done=%b want %b", c, act_strb[c], exp_strb[c]); end
            if (exp_strb[c][4]) begin
                n_cmp++;
                if (act_addr[c] !== exp_addr[c]) begin n_fail++; $display("FAIL nominal mem_addr c%0d: got %h want %h", c, act_addr[c], exp_addr[c]); end
            end
            n_cmp++;
            if (act_data[c] !== exp_data[c]) begin n_fail++; $display("FAIL nominal sh_data c%0d: got %h want %h", c, act_data[c], exp_data[c]); end
        end
        n_cmp++;
        if (act_data[3] !== {4{16'd4}}) begin n_fail++; $display("FAIL nominal first load: got %h want %h", act_data[3], {4{16'd4}}); end
        n_cmp++;
        if (act_strb[11] !== 5'b00001) begin n_fail++; $display("FAIL nominal done c11: got %b want 00001", act_strb[11]); end
    endtask

    task automatic test_stall();
        int ncyc;
        clear_stim();
        g_ready[7] = 1'b0; g_ready[8] = 1'b0; g_ready[9] = 1'b0; g_ready[12] = 1'b0;
        build_expected(8'h10);
        ncyc = g_last + 3;
        run_capture(8'h10, ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            n_cmp++;
            if (act_strb[c] !== exp_strb[c]) begin n_fail++; $display("FAIL stall strobes c%0d: got rd,ld,oe,busy,done=%b want %b", c, act_strb[c], exp_strb[c]); end
            n_cmp++;
            if (act_data[c] !== exp_data[c]) begin n_fail++; $display("FAIL stall sh_data c%0d: got %h want %h", c, act_data[c], exp_data[c]); end
        end
        n_cmp++;
        if (act_strb[15] !== 5'b00001) begin n_fail++; $display("FAIL stall done c15: got %b want 00001", act_strb[15]); end
    endtask

    task automatic test_wrap();
        int ncyc;
        clear_stim();
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        build_expected(8'hFE);
        ncyc = g_last + 3;
        run_capture(8'hFE, ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            n_cmp++;
            if (act_strb[c] !== exp_strb[c]) begin n_fail++; $display("FAIL wrap strobes c%0d: got %b want %b", c, act_strb[c], exp_strb[c]); end
            if (exp_strb[c][4]) begin
                n_cmp++;
                if (act_addr[c] !== exp_addr[c]) begin n_fail++; $display("FAIL wrap mem_addr c%0d: got %h want %h", c, act_addr[c], exp_addr[c]); end
            end
            n_cmp++;
            if (act_data[c] !== exp_data[c]) begin n_fail++; $display("FAIL wrap sh_data c%0d: got %h want %h", c, act_data[c], exp_data[c]); end
        end
        n_cmp++;
        if (act_addr[1] !== 8'h01) begin n_fail++; $display("FAIL wrap first addr: got %h want 01", act_addr[1]); end
    endtask

    task automatic test_start_ignored();
        int ncyc;
        clear_stim();
        build_expected(8'h40);
        g_start[2] = 1'b1;
        g_start[g_last+1] = 1'b1;
        ncyc = g_last + 4;
        run_capture(8'h40, ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            n_cmp++;
            if (act_strb[c] !== exp_strb[c]) begin n_fail++; $display("FAIL start_ignored strobes c%0d: got %b want %b", c, act_strb[c], exp_strb[c]); end
            if (exp_strb[c][4]) begin
                n_cmp++;
                if (act_addr[c] !== exp_addr[c]) begin n_fail++; $display("FAIL start_ignored mem_addr c%0d: got %h want %h", c, act_addr[c], exp_addr[c]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ncyc;
        logic [AW-1:0] b;
        for (int t = 0; t < 2; t++) begin
            clear_stim();
            b = AW'($urandom);
            build_expected(b);
            ncyc = (t == 0) ? g_last + 1 : g_last + 3;
            run_capture(b, ncyc);
            for (int c = 1; c <= ncyc; c++) begin
                n_cmp++;
                if (act_strb[c] !== exp_strb[c]) begin n_fail++; $display("FAIL back_to_back t%0d strobes c%0d: got %b want %b", t, c, act_strb[c], exp_strb[c]); end
                if (exp_strb[c][4]) begin
                    n_cmp++;
                    if (act_addr[c] !== exp_addr[c]) begin n_fail++; $display("FAIL back_to_back t%0d mem_addr c%0d: got %h want %h", t, c, act_addr[c], exp_addr[c]); end
                end
                n_cmp++;
                if (act_data[c] !== exp_data[c]) begin n_fail++; $display("FAIL back_to_back t%0d sh_data c%0d: got %h want %h", t, c, act_data[c], exp_data[c]); end
            end
        end
    endtask

    task automatic test_random();
        int ncyc;
        logic [AW-1:0] b;
        for (int t = 0; t < 6; t++) begin
            clear_stim();
            for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
            for (int c = 0; c <= 30; c++) g_ready[c] = ($urandom_range(0, 3) != 0);
            b = AW'($urandom);
            build_expected(b);
            for (int c = 1; c <= g_last + 1; c++) g_start[c] = ($urandom_range(0, 4) == 0);
            ncyc = g_last + 3;
            run_capture(b, ncyc);
            for (int c = 1; c <= ncyc; c++) begin
                n_cmp++;
                if (act_strb[c] !== exp_strb[c]) begin n_fail++; $display("FAIL random t%0d strobes c%0d: got %b want %b", t, c, act_strb[c], exp_strb[c]); end
                if (exp_strb[c][4]) begin
                    n_cmp++;
                    if (act_addr[c] !== exp_addr[c]) begin n_fail++; $display("FAIL random t%0d mem_addr c%0d: got %h want %h", t, c, act_addr[c], exp_addr[c]); end
                end
                n_cmp++;
                if (act_data[c] !== exp_data[c]) begin n_fail++; $display("FAIL random t%0d sh_data c%0d: got %h want %h", t, c, act_data[c], exp_data[c]); end
            end
        end
    endtask

    task automatic test_reset_midop();
        int ncyc;
        for (int r = 0; r < H; r++) mem[8'h10 + r] = {4{16'(r + 1)}};
        @(negedge clk);
        start = 1'b1; base_addr = 8'h10; array_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_cmp++;
        if ({mem_rd_en, sh_load_en, sh_out_en, busy, done} !== 5'b01010) begin
            n_fail++; $display("FAIL midop pre-reset c5: got %b want 01010", {mem_rd_en, sh_load_en, sh_out_en, busy, done});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_rd_en, sh_load_en, sh_out_en, busy, done} !== 5'b0) begin
            n_fail++; $display("FAIL midop reset strobes: got %b want 00000", {mem_rd_en, sh_load_en, sh_out_en, busy, done});
        end
        n_cmp++;
        if ({mem_addr, sh_data} !== '0) begin n_fail++; $display("FAIL midop reset addr/data: got %h %h want 0", mem_addr, sh_data); end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_rd_en, sh_load_en, sh_out_en, busy, done} !== 5'b0) begin
                n_fail++; $display("FAIL midop post-reset idle %0d: got %b want 00000", c, {mem_rd_en, sh_load_en, sh_out_en, busy, done});
            end
        end
        @(posedge clk); #1;
        g_last_data = '0;
        clear_stim();
        build_expected(8'h10);
        ncyc = g_last + 3;
        run_capture(8'h10, ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            n_cmp++;
            if (act_strb[c] !== exp_strb[c]) begin n_fail++; $display("FAIL midop rerun strobes c%0d: got %b want %b", c, act_strb[c], exp_strb[c]); end
            n_cmp++;
            if (act_data[c] !== exp_data[c]) begin n_fail++; $display("FAIL midop rerun sh_data c%0d: got %h want %h", c, act_data[c], exp_data[c]); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        g_last_data = '0;
        g_last = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_nominal();
        test_stall();
        test_wrap();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
